flash_op_sched: RTL and testbench



---
 rtl/flash_pkg.sv | 47 ++++
 rtl/flash_spi_frame.sv | 117 +++++++++++
 rtl/flash_op_sched.sv | 257 +++++++++++++++++++++++++
 tb/tb_flash_op_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared opcodes, state encodings and requester indices for the M25P16 operation scheduler.
// Optional poll timeout in the top is enabled by defining FLASH_POLL_TIMEOUT_EN.
package flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_BE   = 8'hC7;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_PP   = 8'h02;

    localparam logic [1:0] REQ_BE = 2'd0;
    localparam logic [1:0] REQ_SE = 2'd1;
    localparam logic [1:0] REQ_PP = 2'd2;

    localparam logic [5:0] LEN_OP = 6'd8;
    localparam logic [5:0] LEN_SE = 6'd32;
    localparam logic [5:0] LEN_PP = 6'd40;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WREN = 3'd1,
        S_GAP1 = 3'd2,
        S_CMD  = 3'd3,
        S_GAP2 = 3'd4,
        S_RDSR = 3'd5,
        S_CHK  = 3'd6,
        S_DONE = 3'd7
    } sched_state_e;

    typedef enum logic [2:0] {
        F_IDLE  = 3'd0,
        F_LEAD  = 3'd1,
        F_HIGH  = 3'd2,
        F_LOW   = 3'd3,
        F_TRAIL = 3'd4
    } frame_state_e;

    // Round-robin successor in the fixed order be -> se -> pp -> be.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            REQ_BE:  rr_next = REQ_SE;
            REQ_SE:  rr_next = REQ_PP;
            default: rr_next = REQ_BE;
        endcase
    endfunction

endpackage

// File: rtl/flash_spi_frame.sv
// One SPI mode-0 frame: shifts up to 40 tx bits MSB first, optionally clocks 8 rx bits,
// and owns the cs_n/sck/mosi timing. Start/done handshake towards the sequencer.
module flash_spi_frame
    import flash_pkg::*;
#(
    parameter int SCK_HALF = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [39:0] i_tx_word,
    input  logic [5:0]  i_tx_len,
    input  logic        i_rx_en,
    input  logic        i_miso,
    output logic        o_done,
    output logic [7:0]  o_rx_byte,
    output logic        o_cs_n,
    output logic        o_sck,
    output logic        o_mosi
);

    localparam int DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);

    frame_state_e     r_state;
    logic [DIV_W-1:0] r_div;
    logic [39:0]      r_sh;
    logic [5:0]       r_bits;
    logic [7:0]       r_rx;
    logic             r_cs_n;
    logic             r_sck;
    logic             r_mosi;
    logic             r_done;
    logic             w_div_end;

    assign w_div_end = (r_div == DIV_LAST);

    // Frame timing: lead-in, sck high/low halves per bit, trailing hold before cs_n rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= F_IDLE;
            r_div   <= '0;
            r_sh    <= 40'h0;
            r_bits  <= 6'd0;
            r_rx    <= 8'h00;
            r_cs_n  <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                F_IDLE: begin
                    r_div <= '0;
                    if (i_start) begin
                        r_sh    <= i_tx_word;
                        r_bits  <= i_tx_len + (i_rx_en ? 6'd8 : 6'd0);
                        r_cs_n  <= 1'b0;
                        r_mosi  <= i_tx_word[39];
                        r_state <= F_LEAD;
                    end
                end
                F_LEAD, F_LOW: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_rx    <= {r_rx[6:0], i_miso};
                        r_state <= F_HIGH;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                F_HIGH: begin
                    if (w_div_end) begin
                        r_div  <= '0;
                        r_sck  <= 1'b0;
                        r_bits <= r_bits - 6'd1;
                        if (r_bits == 6'd1) begin
                            r_state <= F_TRAIL;
                        end else begin
                            // Zeros shift in behind the tx word, so rx bits go out as mosi=0.
                            r_sh    <= {r_sh[38:0], 1'b0};
                            r_mosi  <= r_sh[38];
                            r_state <= F_LOW;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                F_TRAIL: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= F_IDLE;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= F_IDLE;
                    r_cs_n  <= 1'b1;
                    r_sck   <= 1'b0;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    assign o_done    = r_done;
    assign o_rx_byte = r_rx;
    assign o_cs_n    = r_cs_n;
    assign o_sck     = r_sck;
    assign o_mosi    = r_mosi;

endmodule

// File: rtl/flash_op_sched.sv
// Round-robin scheduler of bulk erase, sector erase and page program onto one M25P16 bus.
// Define FLASH_POLL_TIMEOUT_EN to bound RDSR polling to POLL_MAX frames (op_err on expiry).
module flash_op_sched
    import flash_pkg::*;
#(
    parameter int          SCK_HALF = 2,
    parameter int          CS_GAP   = 4,
    parameter logic [31:0] POLL_MAX = 32'd1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        be_req,
    input  logic        se_req,
    input  logic [23:0] se_addr,
    input  logic        pp_req,
    input  logic [23:0] pp_addr,
    input  logic [7:0]  pp_data,
    output logic        be_done,
    output logic        se_done,
    output logic        pp_done,
    output logic        busy,
    output logic        op_err,
    output logic        cs_n,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);

    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    sched_state_e     r_state;
    logic [1:0]       r_rr_ptr;
    logic [1:0]       r_op_sel;
    logic [23:0]      r_addr;
    logic [7:0]       r_data;
    logic [GAP_W-1:0] r_gap;
    logic             r_start;
    logic [39:0]      r_tx_word;
    logic [5:0]       r_tx_len;
    logic             r_rx_en;
    logic [7:0]       r_status;
    logic             r_busy;
    logic             r_be_done;
    logic             r_se_done;
    logic             r_pp_done;
`ifdef FLASH_POLL_TIMEOUT_EN
    logic [31:0]      r_poll_cnt;
    logic             r_op_err;
`endif

    logic             w_fdone;
    logic [7:0]       w_rx_byte;
    logic [3:0]       w_req;
    logic [1:0]       w_idx1;
    logic [1:0]       w_idx2;
    logic             w_gnt_vld;
    logic [1:0]       w_gnt_idx;
    logic [39:0]      w_cmd_word;
    logic [5:0]       w_cmd_len;
    logic             w_gap_end;

    assign w_gap_end = (r_gap == GAP_LAST);

    // Pick the first requester at or after the round-robin pointer.
    always_comb begin
        w_req     = {1'b0, pp_req, se_req, be_req};
        w_idx1    = rr_next(r_rr_ptr);
        w_idx2    = rr_next(w_idx1);
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_rr_ptr;
        if (w_req[r_rr_ptr]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = r_rr_ptr;
        end else if (w_req[w_idx1]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_idx1;
        end else if (w_req[w_idx2]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_idx2;
        end else begin
            w_gnt_vld = 1'b0;
            w_gnt_idx = r_rr_ptr;
        end
    end

    // Command frame contents for the latched operation, left-aligned in 40 bits.
    always_comb begin
        case (r_op_sel)
            REQ_SE: begin
                w_cmd_word = {OP_SE, r_addr, 8'h00};
                w_cmd_len  = LEN_SE;
            end
            REQ_PP: begin
                w_cmd_word = {OP_PP, r_addr, r_data};
                w_cmd_len  = LEN_PP;
            end
            default: begin
                w_cmd_word = {OP_BE, 32'h0000_0000};
                w_cmd_len  = LEN_OP;
            end
        endcase
    end

    // Operation sequencer: WREN, command, RDSR polling until WIP clears, done pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= REQ_BE;
            r_op_sel   <= REQ_BE;
            r_addr     <= 24'h0;
            r_data     <= 8'h00;
            r_gap      <= '0;
            r_start    <= 1'b0;
            r_tx_word  <= 40'h0;
            r_tx_len   <= 6'd0;
            r_rx_en    <= 1'b0;
            r_status   <= 8'h00;
            r_busy     <= 1'b0;
            r_be_done  <= 1'b0;
            r_se_done  <= 1'b0;
            r_pp_done  <= 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
            r_poll_cnt <= 32'd0;
            r_op_err   <= 1'b0;
`endif
        end else begin
            r_start   <= 1'b0;
            r_be_done <= 1'b0;
            r_se_done <= 1'b0;
            r_pp_done <= 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
            r_op_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_op_sel  <= w_gnt_idx;
                        r_rr_ptr  <= rr_next(w_gnt_idx);
                        r_addr    <= (w_gnt_idx == REQ_PP) ? pp_addr : se_addr;
                        r_data    <= pp_data;
                        r_busy    <= 1'b1;
                        r_start   <= 1'b1;
                        r_tx_word <= {OP_WREN, 32'h0000_0000};
                        r_tx_len  <= LEN_OP;
                        r_rx_en   <= 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
                        r_poll_cnt <= 32'd0;
`endif
                        r_state   <= S_WREN;
                    end
                end
                S_WREN: begin
                    if (w_fdone) begin
                        r_gap   <= '0;
                        r_state <= S_GAP1;
                    end
                end
                S_GAP1: begin
                    if (w_gap_end) begin
                        r_start   <= 1'b1;
                        r_tx_word <= w_cmd_word;
                        r_tx_len  <= w_cmd_len;
                        r_rx_en   <= 1'b0;
                        r_state   <= S_CMD;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                S_CMD: begin
                    if (w_fdone) begin
                        r_gap   <= '0;
                        r_state <= S_GAP2;
                    end
                end
                S_GAP2: begin
                    if (w_gap_end) begin
                        r_start   <= 1'b1;
                        r_tx_word <= {OP_RDSR, 32'h0000_0000};
                        r_tx_len  <= LEN_OP;
                        r_rx_en   <= 1'b1;
                        r_state   <= S_RDSR;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                S_RDSR: begin
                    if (w_fdone) begin
                        r_status <= w_rx_byte;
`ifdef FLASH_POLL_TIMEOUT_EN
                        r_poll_cnt <= r_poll_cnt + 32'd1;
`endif
                        r_state  <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (!r_status[0]) begin
                        r_be_done <= (r_op_sel == REQ_BE);
                        r_se_done <= (r_op_sel == REQ_SE);
                        r_pp_done <= (r_op_sel == REQ_PP);
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
`ifdef FLASH_POLL_TIMEOUT_EN
                    end else if (r_poll_cnt >= POLL_MAX) begin
                        r_op_err <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
`endif
                    end else begin
                        r_gap   <= '0;
                        r_state <= S_GAP2;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    flash_spi_frame #(
        .SCK_HALF (SCK_HALF)
    ) u_frame (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_start   (r_start),
        .i_tx_word (r_tx_word),
        .i_tx_len  (r_tx_len),
        .i_rx_en   (r_rx_en),
        .i_miso    (miso),
        .o_done    (w_fdone),
        .o_rx_byte (w_rx_byte),
        .o_cs_n    (cs_n),
        .o_sck     (sck),
        .o_mosi    (mosi)
    );

    assign be_done = r_be_done;
    assign se_done = r_se_done;
    assign pp_done = r_pp_done;
    assign busy    = r_busy;

`ifdef FLASH_POLL_TIMEOUT_EN
    logic w_unused;
    assign w_unused = ^r_status[7:1];
    assign op_err   = r_op_err;
`else
    logic w_unused;
    assign w_unused = ^{r_status[7:1], POLL_MAX};
    assign op_err   = 1'b0;
`endif

endmodule

// File: tb/tb_flash_op_sched.sv
// Directed bench for flash_op_sched with a small M25P16 frame/WIP model on the SPI pins.
module tb_flash_op_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        be_req = 1'b0;
    logic        se_req = 1'b0;
    logic        pp_req = 1'b0;
    logic [23:0] se_addr = 24'h0;
    logic [23:0] pp_addr = 24'h0;
    logic [7:0]  pp_data = 8'h00;
    logic        miso;
    logic        be_done, se_done, pp_done, busy, op_err, cs_n, sck, mosi;

    flash_op_sched #(
        .SCK_HALF (2),
        .CS_GAP   (4),
        .POLL_MAX (32'd4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .be_req    (be_req),
        .se_req    (se_req),
        .se_addr   (se_addr),
        .pp_req    (pp_req),
        .pp_addr   (pp_addr),
        .pp_data   (pp_data),
        .be_done   (be_done),
        .se_done   (se_done),
        .pp_done   (pp_done),
        .busy      (busy),
        .op_err    (op_err),
        .cs_n      (cs_n),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #10 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash model: collects each cs_n-low window as (bit count, shifted bits); WIP clears after two busy polls.
    int          m_nb = 0;
    logic [39:0] m_sh = 40'h0;
    logic        m_prev_sck = 1'b0;
    logic        m_prev_cs = 1'b1;
    logic        m_wip = 1'b0;
    int          m_left = 0;
    logic        force_miso = 1'b0;
    int          fr_nb[$];
    logic [39:0] fr_d[$];

    assign miso = m_wip | force_miso;

    always @(posedge sys_clk) begin
        m_prev_sck <= sck;
        m_prev_cs  <= cs_n;
        if (!cs_n && sck && !m_prev_sck) begin
            m_sh <= {m_sh[38:0], mosi};
            m_nb <= m_nb + 1;
        end
        if (cs_n) begin
            m_nb <= 0;
            m_sh <= 40'h0;
        end
        if (cs_n && !m_prev_cs) begin
            fr_nb.push_back(m_nb);
            fr_d.push_back(m_sh);
            if ((m_nb == 8 && m_sh[7:0] == 8'hC7) || (m_nb == 32 && m_sh[31:24] == 8'hD8) ||
                (m_nb == 40 && m_sh[39:32] == 8'h02)) begin
                m_wip  <= 1'b1;
                m_left <= 2;
            end else if (m_nb == 16 && m_sh[15:8] == 8'h05 && m_wip) begin
                if (m_left <= 1) m_wip <= 1'b0;
                m_left <= m_left - 1;
            end
        end
    end

    // Done/op_err pulse monitor: counts, service order, and pulses wider than one cycle.
    int         be_cnt = 0, se_cnt = 0, pp_cnt = 0, err_cnt = 0, wide_cnt = 0;
    int         order[$];
    logic [3:0] prev_p = 4'b0;

    always @(posedge sys_clk) begin
        prev_p <= {be_done, se_done, pp_done, op_err};
        if (be_done) begin be_cnt <= be_cnt + 1; order.push_back(0); end
        if (se_done) begin se_cnt <= se_cnt + 1; order.push_back(1); end
        if (pp_done) begin pp_cnt <= pp_cnt + 1; order.push_back(2); end
        if (op_err)  err_cnt <= err_cnt + 1;
        if ((prev_p & {be_done, se_done, pp_done, op_err}) != 4'b0) wide_cnt <= wide_cnt + 1;
    end

    task automatic run_op(input logic [2:0] mask, input int n_exp, input string tag);
        int seen = 0;
        int cyc = 0;
        be_req = mask[2];
        se_req = mask[1];
        pp_req = mask[0];
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd1);
        while (seen < n_exp && cyc < 20000) begin
            @(negedge sys_clk);
            cyc++;
            if (be_done) begin be_req = 1'b0; seen++; end
            if (se_done) begin se_req = 1'b0; seen++; end
            if (pp_done) begin pp_req = 1'b0; seen++; end
        end
        check_eq({tag, "_dones"}, 64'(seen), 64'(n_exp));
        be_req = 1'b0;
        se_req = 1'b0;
        pp_req = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_eq({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_frame(input string tag, input int idx, input int nb, input logic [39:0] d);
        check_eq({tag, "_bits"}, 64'(fr_nb[idx]), 64'(nb));
        check_eq({tag, "_data"}, {24'h0, fr_d[idx]}, {24'h0, d});
    endtask

    int base;
    int o;
    int b0;
    int e0;
    int cyc;
    logic hit;

    initial begin
        repeat (3) @(negedge sys_clk);
        check_eq("reset_outs", {56'd0, cs_n, sck, mosi, busy, be_done, se_done, pp_done, op_err},
                 {56'd0, 8'b1000_0000});
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        base = fr_nb.size(); o = order.size();
        run_op(3'b100, 1, "be");
        check_eq("be_nframes", 64'(fr_nb.size() - base), 64'd5);
        check_frame("be_wren", base, 8, 40'h06);
        check_frame("be_cmd", base + 1, 8, 40'hC7);
        for (int k = 2; k < 5; k++) check_frame("be_rdsr", base + k, 16, 40'h0500);
        check_eq("be_who", 64'(order[o]), 64'd0);

        se_addr = 24'h01_2345;
        base = fr_nb.size(); o = order.size();
        run_op(3'b010, 1, "se");
        check_eq("se_nframes", 64'(fr_nb.size() - base), 64'd5);
        check_frame("se_cmd", base + 1, 32, 40'hD8_012345);
        check_eq("se_who", 64'(order[o]), 64'd1);

        pp_addr = 24'h00_0010;
        pp_data = 8'hA5;
        base = fr_nb.size(); o = order.size();
        run_op(3'b001, 1, "pp");
        check_frame("pp_cmd", base + 1, 40, 40'h02_000010_A5);
        check_eq("pp_who", 64'(order[o]), 64'd2);

        base = fr_nb.size(); o = order.size();
        run_op(3'b111, 3, "rr");
        check_eq("rr_nframes", 64'(fr_nb.size() - base), 64'd15);
        for (int k = 0; k < 3; k++) check_eq("rr_order", 64'(order[o + k]), 64'(k));
        check_frame("rr_be_cmd", base + 1, 8, 40'hC7);
        check_frame("rr_se_cmd", base + 6, 32, 40'hD8_012345);
        check_frame("rr_pp_cmd", base + 11, 40, 40'h02_000010_A5);

        // Reset while the command frame is on the wire.
        base = fr_nb.size();
        be_req = 1'b1;
        hit = 1'b0;
        for (cyc = 0; cyc < 5000 && !hit; cyc++) begin
            @(negedge sys_clk);
            if (fr_nb.size() > base && !cs_n) hit = 1'b1;
        end
        check_eq("rst_reach_cmd", {63'd0, hit}, 64'd1);
        repeat (6) @(negedge sys_clk);
        b0 = be_cnt;
        sys_rst_n = 1'b0;
        #1;
        check_eq("rst_pins", {61'd0, cs_n, sck, busy}, {61'd0, 3'b100});
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_eq("rst_no_done", 64'(be_cnt), 64'(b0));
        base = fr_nb.size();
        run_op(3'b100, 1, "resvc");
        check_frame("resvc_wren", base, 8, 40'h06);
        check_frame("resvc_cmd", base + 1, 8, 40'hC7);

`ifdef FLASH_POLL_TIMEOUT_EN
        base = fr_nb.size(); b0 = be_cnt; e0 = err_cnt;
        force_miso = 1'b1;
        be_req = 1'b1;
        hit = 1'b0;
        for (cyc = 0; cyc < 20000 && !hit; cyc++) begin
            @(negedge sys_clk);
            if (op_err) begin hit = 1'b1; be_req = 1'b0; end
        end
        check_eq("to_op_err", {63'd0, hit}, 64'd1);
        repeat (2) @(negedge sys_clk);
        check_eq("to_busy", {63'd0, busy}, 64'd0);
        check_eq("to_nframes", 64'(fr_nb.size() - base), 64'd6);
        check_eq("to_no_done", 64'(be_cnt), 64'(b0));
        check_eq("to_err_cnt", 64'(err_cnt), 64'(e0 + 1));
        force_miso = 1'b0;
`else
        check_eq("op_err_never", 64'(err_cnt), 64'd0);
`endif
        check_eq("pulse_width", 64'(wide_cnt), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
